// File: rtl/ub_read_sequencer_if.sv
// Command/config inputs and UB read-port outputs of the UB read sequencer.
// The master drives start and the run configuration; the slave is the sequencer.
interface ub_read_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  k_len;
    logic [ADDR_WIDTH-1:0] input_base;
    logic [ADDR_WIDTH-1:0] input_stride;
    logic [ADDR_WIDTH-1:0] weight_base;
    logic [ADDR_WIDTH-1:0] weight_stride;

    logic [ADDR_WIDTH-1:0] input_addr;
    logic                  input_first_in;
    logic                  input_last_in;
    logic [ADDR_WIDTH-1:0] weight_addr;
    logic                  weight_first_in;
    logic                  weight_last_in;
    logic                  en;
    logic                  busy;
    logic                  done;

    modport master (
        output start, k_len, input_base, input_stride, weight_base, weight_stride,
        input  input_addr, input_first_in, input_last_in,
               weight_addr, weight_first_in, weight_last_in, en, busy, done
    );

    modport slave (
        input  start, k_len, input_base, input_stride, weight_base, weight_stride,
        output input_addr, input_first_in, input_last_in,
               weight_addr, weight_first_in, weight_last_in, en, busy, done
    );
endinterface

// File: rtl/ub_read_sequencer.sv
// Issues K lockstep read beats on the UB input/weight channels, keeps the
// skewer enabled through the drain window, then pulses done.
module ub_read_sequencer #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int UB_LATENCY = 1
) (
    input logic             clk,
    input logic             rst,
    ub_read_sequencer_if.slave bus
);
    localparam int D  = UB_LATENCY + N;
    localparam int DW = $clog2(D + 1);
    localparam int NCH = 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  first;
        logic                  last;
    } chan_t;

    state_t                          state, state_nxt;
    logic [CNT_WIDTH-1:0]            k_q, k_d;
    logic [CNT_WIDTH-1:0]            beat_q, beat_d;
    logic [DW-1:0]                   drain_q, drain_d;
    logic [NCH-1:0][ADDR_WIDTH-1:0]  stride_q, stride_d;
    chan_t [NCH-1:0]                 ch_q, ch_d;
    logic                            en_q, en_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    // Outputs are the registered next-cycle view, so beat 0 appears the
    // cycle after start is taken. beat_q counts beats already issued.
    always_comb begin
        state_nxt = state;
        k_d       = k_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        stride_d  = stride_q;
        ch_d      = '0;
        en_d      = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    k_d         = bus.k_len;
                    stride_d[0] = bus.input_stride;
                    stride_d[1] = bus.weight_stride;
                    beat_d      = '0;
                    drain_d     = '0;
                    if (bus.k_len == '0) begin
                        state_nxt = DONE;
                        done_d    = 1'b1;
                    end else begin
                        state_nxt  = STREAM;
                        ch_d[0]    = '{bus.input_base,  1'b1, bus.k_len == CNT_WIDTH'(1)};
                        ch_d[1]    = '{bus.weight_base, 1'b1, bus.k_len == CNT_WIDTH'(1)};
                        en_d       = 1'b1;
                        busy_d     = 1'b1;
                        beat_d     = CNT_WIDTH'(1);
                    end
                end
            end
            STREAM: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
                if (beat_q == k_q) begin
                    state_nxt = DRAIN;
                    drain_d   = DW'(1);
                end else begin
                    // Accumulate from the address currently on the port; wrap is silent.
                    for (int c = 0; c < NCH; c++) begin
                        ch_d[c].addr = ch_q[c].addr + stride_q[c];
                        ch_d[c].last = (beat_q == k_q - CNT_WIDTH'(1));
                    end
                    beat_d = beat_q + CNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DW'(D)) begin
                    state_nxt = DONE;
                    done_d    = 1'b1;
                end else begin
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                beat_d    = '0;
                drain_d   = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k_q      <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            stride_q <= '0;
            ch_q     <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            k_q      <= k_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            stride_q <= stride_d;
            ch_q     <= ch_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.input_addr      = ch_q[0].addr;
    assign bus.input_first_in  = ch_q[0].first;
    assign bus.input_last_in   = ch_q[0].last;
    assign bus.weight_addr     = ch_q[1].addr;
    assign bus.weight_first_in = ch_q[1].first;
    assign bus.weight_last_in  = ch_q[1].last;
    assign bus.en              = en_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule
